// File: rtl/svc_soc_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : svc_soc_run_ctrl
// Description : Run-lifecycle sequencer for the simulated RISC-V SoC.
//               Holds the CPU in reset and then releases it. It watches for
//               halt (ebreak), trap or watchdog expiry, then stops the CPU.
//               It waits for the UART transmitter to drain and publishes a
//               single done/pass verdict used by the sim top to end the run.
//
// Ports       : clk         system clock
//               rst_n       asynchronous active-low reset
//               start       pulse, begins a run from IDLE or DONE
//               cpu_halt    CPU retired ebreak (sampled in RUN only)
//               cpu_trap    CPU illegal instruction / misaligned access
//               cpu_retire  one instruction retired this cycle
//               uart_busy   UART TX FIFO non-empty or shifting
//               cpu_rst_n   active-low reset to CPU and memories
//               cpu_run     CPU clock enable
//               running     high in RUN
//               done        high in DONE
//               pass        verdict, valid (and only ever high) in DONE
//               status      0 none, 1 halt, 2 trap, 3 timeout
//               drain_err   DRAIN ended by DRAIN_TIMEOUT
//               cycles      RUN cycles of the current/last run
//               instret     retired instructions of the current/last run
//
// Revision    : 1.0 - initial release
// ============================================================================
module svc_soc_run_ctrl #(
    parameter int unsigned RESET_HOLD       = 8,
    parameter int unsigned WATCHDOG_CYCLES  = 1_000_000,
    parameter int unsigned UART_IDLE_CYCLES = 4,
    parameter int unsigned DRAIN_TIMEOUT    = 100_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        cpu_halt,
    input  logic        cpu_trap,
    input  logic        cpu_retire,
    input  logic        uart_busy,
    output logic        cpu_rst_n,
    output logic        cpu_run,
    output logic        running,
    output logic        done,
    output logic        pass,
    output logic [1:0]  status,
    output logic        drain_err,
    output logic [31:0] cycles,
    output logic [31:0] instret
);

    // ------------------------------------------------------------------------
    // Constants. Internal counters carry one bit more than strictly needed so
    // the terminal value is always representable and never wraps to zero.
    // ------------------------------------------------------------------------
    localparam int unsigned c_hold_w  = $clog2(RESET_HOLD) + 1;
    localparam int unsigned c_idle_w  = $clog2(UART_IDLE_CYCLES) + 1;
    localparam int unsigned c_drain_w = $clog2(DRAIN_TIMEOUT) + 1;

    localparam logic [c_hold_w-1:0]  c_hold_last   = c_hold_w'(RESET_HOLD - 1);
    localparam logic [c_idle_w-1:0]  c_idle_target = c_idle_w'(UART_IDLE_CYCLES);
    localparam logic [c_drain_w-1:0] c_drain_limit = c_drain_w'(DRAIN_TIMEOUT);
    localparam logic [31:0]          c_wd_last     = 32'(WATCHDOG_CYCLES - 1);
    localparam logic [31:0]          c_cnt_max     = 32'hFFFF_FFFF;

    localparam logic [1:0] c_status_none    = 2'd0;
    localparam logic [1:0] c_status_halt    = 2'd1;
    localparam logic [1:0] c_status_trap    = 2'd2;
    localparam logic [1:0] c_status_timeout = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RESET = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    state_t               r_state;
    logic [c_hold_w-1:0]  r_hold_cnt;
    logic [c_idle_w-1:0]  r_idle_cnt;
    logic [c_drain_w-1:0] r_drain_cnt;

    logic        r_cpu_rst_n;
    logic        r_cpu_run;
    logic        r_running;
    logic        r_done;
    logic        r_pass;
    logic [1:0]  r_status;
    logic        r_drain_err;
    logic [31:0] r_cycles;
    logic [31:0] r_instret;

    // ------------------------------------------------------------------------
    // Next-value helpers
    // ------------------------------------------------------------------------
    logic [31:0]          w_cycles_next;
    logic [31:0]          w_instret_next;
    logic                 w_wd_expire;
    logic [c_idle_w-1:0]  w_idle_next;
    logic [c_drain_w-1:0] w_drain_next;
    logic                 w_idle_reached;
    logic                 w_drain_expired;

    always_comb begin
        // Saturating run counters
        w_cycles_next  = (r_cycles == c_cnt_max) ? r_cycles : r_cycles + 32'd1;
        w_instret_next = r_instret;
        if (cpu_retire && (r_instret != c_cnt_max)) begin
            w_instret_next = r_instret + 32'd1;
        end

        // The watchdog compares the pre-increment count, so the expiry cycle
        // itself is still counted and a timeout leaves cycles at the limit.
        w_wd_expire = (r_cycles == c_wd_last);

        // Quiet-time counter restarts on any busy cycle
        w_idle_next     = uart_busy ? '0 : r_idle_cnt + c_idle_w'(1);
        w_drain_next    = r_drain_cnt + c_drain_w'(1);
        w_idle_reached  = (w_idle_next == c_idle_target);
        w_drain_expired = (w_drain_next == c_drain_limit);
    end

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_hold_cnt  <= '0;
            r_idle_cnt  <= '0;
            r_drain_cnt <= '0;
            r_cpu_rst_n <= 1'b0;
            r_cpu_run   <= 1'b0;
            r_running   <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_status    <= c_status_none;
            r_drain_err <= 1'b0;
            r_cycles    <= '0;
            r_instret   <= '0;
        end else begin
            case (r_state)
                // A new run can begin either from power-up or after a verdict;
                // the previous run's results are wiped on entry to RESET.
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state     <= ST_RESET;
                        r_hold_cnt  <= '0;
                        r_cpu_rst_n <= 1'b0;
                        r_cpu_run   <= 1'b0;
                        r_running   <= 1'b0;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_status    <= c_status_none;
                        r_drain_err <= 1'b0;
                        r_cycles    <= '0;
                        r_instret   <= '0;
                    end
                end

                ST_RESET: begin
                    if (r_hold_cnt == c_hold_last) begin
                        r_state     <= ST_RUN;
                        r_cpu_rst_n <= 1'b1;
                        r_cpu_run   <= 1'b1;
                        r_running   <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + c_hold_w'(1);
                    end
                end

                ST_RUN: begin
                    // The exit cycle counts towards both counters
                    r_cycles  <= w_cycles_next;
                    r_instret <= w_instret_next;
                    if (cpu_trap || cpu_halt || w_wd_expire) begin
                        if (cpu_trap) begin
                            r_status <= c_status_trap;
                        end else if (cpu_halt) begin
                            r_status <= c_status_halt;
                        end else begin
                            r_status <= c_status_timeout;
                        end
                        // CPU stays out of reset so its state can be inspected
                        r_state     <= ST_DRAIN;
                        r_cpu_run   <= 1'b0;
                        r_running   <= 1'b0;
                        r_idle_cnt  <= '0;
                        r_drain_cnt <= '0;
                    end
                end

                ST_DRAIN: begin
                    r_idle_cnt  <= w_idle_next;
                    r_drain_cnt <= w_drain_next;
                    // A clean drain takes precedence over a coincident timeout
                    if (w_idle_reached) begin
                        r_state     <= ST_DONE;
                        r_done      <= 1'b1;
                        r_drain_err <= 1'b0;
                        r_pass      <= (r_status == c_status_halt);
                    end else if (w_drain_expired) begin
                        r_state     <= ST_DONE;
                        r_done      <= 1'b1;
                        r_drain_err <= 1'b1;
                        r_pass      <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign cpu_rst_n = r_cpu_rst_n;
    assign cpu_run   = r_cpu_run;
    assign running   = r_running;
    assign done      = r_done;
    assign pass      = r_pass;
    assign status    = r_status;
    assign drain_err = r_drain_err;
    assign cycles    = r_cycles;
    assign instret   = r_instret;

endmodule
`default_nettype wire
